// File: rtl/silife_gen_scheduler.sv
// Generation scheduler for the 32x32 Game-of-Life grid: free-run, single-step
// and N-generation bursts, stalled by grid access, sync traffic and display frames.
module silife_gen_scheduler #(
   parameter int unsigned PERIOD_BITS = 24,
   parameter int unsigned BURST_BITS  = 16,
   parameter int unsigned COUNT_BITS  = 32
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   i_run,
   input  logic                   i_step,
   input  logic                   i_burst_start,
   input  logic [BURST_BITS-1:0]  i_burst_count,
   input  logic                   i_abort,
   input  logic [PERIOD_BITS-1:0] i_period,
   input  logic                   i_period_load,
   input  logic                   i_hold,
   input  logic                   i_sync_busy,
   input  logic                   i_frame_sync_en,
   input  logic                   i_frame_done,
   input  logic                   i_count_clear,
   output logic                   o_gen_en,
   output logic [COUNT_BITS-1:0]  o_gen_count,
   output logic [BURST_BITS-1:0]  o_burst_remaining,
   output logic                   o_active,
   output logic                   o_done
);

   localparam logic [1:0] S_IDLE       = 2'd0;
   localparam logic [1:0] S_ARMED      = 2'd1;
   localparam logic [1:0] S_FIRE       = 2'd2;
   localparam logic [1:0] S_FRAME_WAIT = 2'd3;

   logic [1:0]             r_state;
   logic [1:0]             w_state_nxt;
   logic                   r_step_pending;
   logic                   w_step_pending_nxt;
   logic [BURST_BITS-1:0]  r_burst_remaining;
   logic [BURST_BITS-1:0]  w_burst_nxt;
   logic [PERIOD_BITS-1:0] r_prescaler;
   logic [PERIOD_BITS-1:0] w_prescaler_nxt;
   logic [PERIOD_BITS-1:0] w_period_eff;
   logic [COUNT_BITS-1:0]  r_gen_count;
   logic [COUNT_BITS-1:0]  w_gen_count_nxt;
   logic                   r_gen_en;
   logic                   r_active;
   logic                   r_done;
   logic                   w_done_nxt;
   logic                   w_blocked;
   logic                   w_request_nxt;
   logic                   w_fire_ok;

   assign w_blocked    = i_hold | i_sync_busy;
   assign w_period_eff = (i_period == '0) ? PERIOD_BITS'(1) : i_period;

   // Requests as they stand after this cycle; abort beats new step/burst loads.
   always_comb begin : request_next
      w_step_pending_nxt = r_step_pending;
      w_burst_nxt        = r_burst_remaining;
      w_request_nxt      = 1'b0;
      if (i_abort) begin
         w_step_pending_nxt = 1'b0;
         w_burst_nxt        = '0;
      end else begin
         if (i_step) begin
            w_step_pending_nxt = 1'b1;
         end else if (r_state == S_FIRE) begin
            w_step_pending_nxt = 1'b0;
         end
         if (i_burst_start) begin
            w_burst_nxt = i_burst_count;
         end else if ((r_state == S_FIRE) && (r_burst_remaining != '0)) begin
            w_burst_nxt = r_burst_remaining - BURST_BITS'(1);
         end
      end
      w_request_nxt = w_step_pending_nxt | (w_burst_nxt != '0) | i_run;
   end

   // Next-state logic; a single step bypasses the prescaler.
   always_comb begin : fsm_next
      w_state_nxt = r_state;
      w_fire_ok   = (r_step_pending | (r_prescaler == '0)) & ~w_blocked;
      case (r_state)
         S_IDLE: begin
            if (w_request_nxt) w_state_nxt = S_ARMED;
         end
         S_ARMED: begin
            if (!w_request_nxt)  w_state_nxt = S_IDLE;
            else if (w_fire_ok)  w_state_nxt = S_FIRE;
         end
         S_FIRE: begin
            if (i_frame_sync_en)    w_state_nxt = S_FRAME_WAIT;
            else if (w_request_nxt) w_state_nxt = S_ARMED;
            else                    w_state_nxt = S_IDLE;
         end
         S_FRAME_WAIT: begin
            if (!i_frame_sync_en || i_frame_done) begin
               w_state_nxt = w_request_nxt ? S_ARMED : S_IDLE;
            end
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   // Prescaler is reloaded as a fire is issued, so the FIRE cycle counts as period cycle one.
   always_comb begin : datapath_next
      w_prescaler_nxt = r_prescaler;
      w_gen_count_nxt = r_gen_count;
      w_done_nxt      = 1'b0;
      if (i_period_load || (w_state_nxt == S_FIRE)) begin
         w_prescaler_nxt = w_period_eff;
      end else if (((r_state == S_ARMED) || (r_state == S_FIRE)) && (r_prescaler != '0)) begin
         w_prescaler_nxt = r_prescaler - PERIOD_BITS'(1);
      end
      if (i_count_clear) begin
         w_gen_count_nxt = '0;
      end else if (r_state == S_FIRE) begin
         w_gen_count_nxt = r_gen_count + COUNT_BITS'(1);
      end
      w_done_nxt = (r_state == S_FIRE) && (r_burst_remaining == BURST_BITS'(1))
                   && !i_abort && !i_burst_start;
   end

   always_ff @(posedge clk) begin : state_regs
      if (reset) begin
         r_state           <= S_IDLE;
         r_step_pending    <= 1'b0;
         r_burst_remaining <= '0;
         r_prescaler       <= '0;
         r_gen_count       <= '0;
         r_gen_en          <= 1'b0;
         r_active          <= 1'b0;
         r_done            <= 1'b0;
      end else begin
         r_state           <= w_state_nxt;
         r_step_pending    <= w_step_pending_nxt;
         r_burst_remaining <= w_burst_nxt;
         r_prescaler       <= w_prescaler_nxt;
         r_gen_count       <= w_gen_count_nxt;
         r_gen_en          <= (w_state_nxt == S_FIRE);
         r_active          <= (w_state_nxt != S_IDLE) | w_request_nxt;
         r_done            <= w_done_nxt;
      end
   end

   assign o_gen_en          = r_gen_en;
   assign o_gen_count       = r_gen_count;
   assign o_burst_remaining = r_burst_remaining;
   assign o_active          = r_active;
   assign o_done            = r_done;

endmodule

// File: tb/tb_silife_gen_scheduler.sv
// Self-checking bench for silife_gen_scheduler: directed scenarios plus a
// randomized run against a rule-level reference model.
module tb_silife_gen_scheduler;

   localparam int unsigned PERIOD_BITS = 24;
   localparam int unsigned BURST_BITS  = 16;
   localparam int unsigned COUNT_BITS  = 32;
   localparam int unsigned SMALL_BITS  = 4;

   logic                   clk = 1'b0;
   logic                   reset;
   logic                   i_run, i_step, i_burst_start, i_abort, i_period_load;
   logic [BURST_BITS-1:0]  i_burst_count;
   logic [PERIOD_BITS-1:0] i_period;
   logic                   i_hold, i_sync_busy, i_frame_sync_en, i_frame_done, i_count_clear;
   logic                   o_gen_en, o_active, o_done;
   logic [COUNT_BITS-1:0]  o_gen_count;
   logic [BURST_BITS-1:0]  o_burst_remaining;
   logic                   s_gen_en, s_active, s_done;
   logic [SMALL_BITS-1:0]  s_gen_count;
   logic [BURST_BITS-1:0]  s_burst_remaining;

   int n_checks = 0;
   int n_fail   = 0;
   logic [31:0] exp_count;

   // reference model
   bit          m_armed, m_firing, m_fw, m_step, m_gen_en, m_done, m_active;
   int unsigned m_burst, m_countdown;
   logic [31:0] m_count;

   silife_gen_scheduler #(.PERIOD_BITS(PERIOD_BITS), .BURST_BITS(BURST_BITS), .COUNT_BITS(COUNT_BITS)) dut (
      .clk(clk), .reset(reset), .i_run(i_run), .i_step(i_step), .i_burst_start(i_burst_start),
      .i_burst_count(i_burst_count), .i_abort(i_abort), .i_period(i_period), .i_period_load(i_period_load),
      .i_hold(i_hold), .i_sync_busy(i_sync_busy), .i_frame_sync_en(i_frame_sync_en),
      .i_frame_done(i_frame_done), .i_count_clear(i_count_clear), .o_gen_en(o_gen_en),
      .o_gen_count(o_gen_count), .o_burst_remaining(o_burst_remaining), .o_active(o_active), .o_done(o_done));

   silife_gen_scheduler #(.PERIOD_BITS(PERIOD_BITS), .BURST_BITS(BURST_BITS), .COUNT_BITS(SMALL_BITS)) dut_small (
      .clk(clk), .reset(reset), .i_run(i_run), .i_step(i_step), .i_burst_start(i_burst_start),
      .i_burst_count(i_burst_count), .i_abort(i_abort), .i_period(i_period), .i_period_load(i_period_load),
      .i_hold(i_hold), .i_sync_busy(i_sync_busy), .i_frame_sync_en(i_frame_sync_en),
      .i_frame_done(i_frame_done), .i_count_clear(i_count_clear), .o_gen_en(s_gen_en),
      .o_gen_count(s_gen_count), .o_burst_remaining(s_burst_remaining), .o_active(s_active), .o_done(s_done));

   always #5 clk = ~clk;

   // Applies the scheduling rules to the inputs seen at this clock edge.
   task automatic model_edge();
      bit          blocked, step_after, want, go, n_armed, n_fw, leave;
      int unsigned burst_after;
      if (reset) begin
         m_armed = 0; m_firing = 0; m_fw = 0; m_step = 0; m_gen_en = 0; m_done = 0;
         m_active = 0; m_burst = 0; m_countdown = 0; m_count = '0;
         return;
      end
      blocked     = i_hold || i_sync_busy;
      step_after  = i_abort ? 1'b0 : (i_step ? 1'b1 : (m_firing ? 1'b0 : m_step));
      burst_after = i_abort ? 0 : (i_burst_start ? int'(i_burst_count)
                    : ((m_firing && m_burst != 0) ? m_burst - 1 : m_burst));
      want        = step_after || (burst_after != 0) || i_run;
      go          = m_armed && want && (m_step || m_countdown == 0) && !blocked;
      n_armed = 0; n_fw = 0;
      if (m_firing) begin
         n_fw    = i_frame_sync_en;
         n_armed = !i_frame_sync_en && want;
      end else if (m_fw) begin
         leave   = !i_frame_sync_en || i_frame_done;
         n_fw    = !leave;
         n_armed = leave && want;
      end else if (m_armed) begin
         n_armed = want && !go;
      end else begin
         n_armed = want;
      end
      if (i_period_load || go)
         m_countdown = (i_period == 0) ? 1 : int'(i_period);
      else if ((m_armed || m_firing) && m_countdown > 0)
         m_countdown = m_countdown - 1;
      m_done   = m_firing && (m_burst == 1) && !i_abort && !i_burst_start;
      if (i_count_clear) m_count = '0;
      else if (m_firing) m_count = m_count + 32'd1;
      m_step   = step_after;
      m_burst  = burst_after;
      m_gen_en = go;
      m_active = n_armed || n_fw || go || want;
      m_armed  = n_armed;
      m_fw     = n_fw;
      m_firing = go;
   endtask

   task automatic tick();
      @(posedge clk);
      model_edge();
      #1;
   endtask

   task automatic test_reset();
      if ({o_gen_en, o_done, o_active} !== 3'b000) begin
         n_fail++; $display("FAIL reset_flags got %b exp 000", {o_gen_en, o_done, o_active});
      end
      n_checks++;
      if (o_gen_count !== 32'd0) begin
         n_fail++; $display("FAIL reset_count got %0d exp 0", o_gen_count);
      end
      n_checks++;
      if (o_burst_remaining !== 16'd0) begin
         n_fail++; $display("FAIL reset_burst got %0d exp 0", o_burst_remaining);
      end
      n_checks++;
   endtask

   task automatic test_single_step();
      i_step = 1; tick(); i_step = 0;
      if (o_gen_en !== 1'b0) begin n_fail++; $display("FAIL step_c1 gen_en got %b exp 0", o_gen_en); end
      n_checks++;
      tick();
      if (o_gen_en !== 1'b1) begin n_fail++; $display("FAIL step_c2 gen_en got %b exp 1", o_gen_en); end
      n_checks++;
      tick();
      exp_count = 32'd1;
      if ({o_gen_en, o_active, o_gen_count} !== {2'b00, exp_count}) begin
         n_fail++; $display("FAIL step_c3 en/active/count got %b/%b/%0d exp 0/0/%0d", o_gen_en, o_active, o_gen_count, exp_count);
      end
      n_checks++;
   endtask

   task automatic test_free_run();
      bit exp_p;
      i_period = 24'd4; i_period_load = 1; tick(); i_period_load = 0;
      i_run = 1;
      for (int c = 1; c <= 40; c++) begin
         tick();
         exp_p = (c >= 6) && ((c - 6) % 5 == 0);
         if (o_gen_en !== exp_p) begin
            n_fail++; $display("FAIL freerun_pulse cycle %0d got %b exp %b", c, o_gen_en, exp_p);
         end
         n_checks++;
      end
      i_run = 0; tick(); tick();
      exp_count = exp_count + 32'd7;
      if (o_gen_count !== exp_count) begin
         n_fail++; $display("FAIL freerun_count got %0d exp %0d", o_gen_count, exp_count);
      end
      n_checks++;
   endtask

   task automatic test_burst();
      bit exp_p;
      int exp_rem;
      i_period = 24'd0; i_period_load = 1; tick(); i_period_load = 0;
      i_burst_count = 16'd3; i_burst_start = 1; tick(); i_burst_start = 0;
      for (int c = 1; c <= 12; c++) begin
         exp_p   = (c == 3) || (c == 5) || (c == 7);
         exp_rem = (c <= 3) ? 3 : (c <= 5) ? 2 : (c <= 7) ? 1 : 0;
         if ({o_gen_en, o_done, o_burst_remaining} !== {exp_p, (c == 8), 16'(exp_rem)}) begin
            n_fail++; $display("FAIL burst cycle %0d en/done/rem got %b/%b/%0d exp %b/%b/%0d",
                               c, o_gen_en, o_done, o_burst_remaining, exp_p, (c == 8), exp_rem);
         end
         n_checks++;
         if (c < 12) tick();
      end
      exp_count = exp_count + 32'd3;
      if ({o_active, o_gen_count} !== {1'b0, exp_count}) begin
         n_fail++; $display("FAIL burst_end active/count got %b/%0d exp 0/%0d", o_active, o_gen_count, exp_count);
      end
      n_checks++;
   endtask

   task automatic test_stall(input bit use_sync);
      int pulses = 0;
      if (use_sync) i_sync_busy = 1; else i_hold = 1;
      i_step = 1; tick(); i_step = 0;
      for (int c = 0; c < 10; c++) begin
         tick();
         if (o_gen_en) pulses++;
      end
      if (pulses !== 0) begin n_fail++; $display("FAIL stall_blocked sync=%0b pulses got %0d exp 0", use_sync, pulses); end
      n_checks++;
      i_sync_busy = 0; i_hold = 0; tick();
      if (o_gen_en !== 1'b1) begin n_fail++; $display("FAIL stall_release sync=%0b gen_en got %b exp 1", use_sync, o_gen_en); end
      n_checks++;
      tick(); tick();
      exp_count = exp_count + 32'd1;
      if ({o_active, o_gen_count} !== {1'b0, exp_count}) begin
         n_fail++; $display("FAIL stall_after sync=%0b active/count got %b/%0d exp 0/%0d", use_sync, o_active, o_gen_count, exp_count);
      end
      n_checks++;
   endtask

   task automatic test_frame_sync();
      bit found = 0;
      int pulses = 0;
      i_period = 24'd0; i_period_load = 1; tick(); i_period_load = 0;
      i_frame_sync_en = 1; i_run = 1;
      for (int c = 0; c < 12 && !found; c++) begin
         tick();
         found = o_gen_en;
      end
      if (!found) begin n_fail++; $display("FAIL frame_first pulse got none exp within 12 cycles"); end
      n_checks++;
      for (int c = 0; c < 7; c++) begin
         tick();
         if (o_gen_en) pulses++;
      end
      if (pulses !== 0) begin n_fail++; $display("FAIL frame_wait pulses got %0d exp 0", pulses); end
      n_checks++;
      i_frame_done = 1; tick(); i_frame_done = 0;
      if (o_gen_en !== 1'b0) begin n_fail++; $display("FAIL frame_done+1 gen_en got %b exp 0", o_gen_en); end
      n_checks++;
      tick();
      if (o_gen_en !== 1'b1) begin n_fail++; $display("FAIL frame_done+2 gen_en got %b exp 1", o_gen_en); end
      n_checks++;
      tick();
      reset = 1; i_run = 0; i_frame_sync_en = 0; tick();
      if ({o_gen_en, o_done, o_active, o_burst_remaining, o_gen_count} !== 51'd0) begin
         n_fail++; $display("FAIL frame_reset en/done/active/rem/count got %b/%b/%b/%0d/%0d exp all 0",
                            o_gen_en, o_done, o_active, o_burst_remaining, o_gen_count);
      end
      n_checks++;
      reset = 0; tick();
      if ({o_gen_en, o_active} !== 2'b00) begin n_fail++; $display("FAIL frame_post_reset en/active got %b exp 00", {o_gen_en, o_active}); end
      n_checks++;
      exp_count = 32'd0;
   endtask

   task automatic test_corners();
      bit found = 0;
      int dones = 0;
      // abort mid-burst
      i_period = 24'd0; i_period_load = 1; tick(); i_period_load = 0;
      i_burst_count = 16'd8; i_burst_start = 1; tick(); i_burst_start = 0;
      for (int c = 0; c < 40 && !found; c++) begin
         if (o_burst_remaining == 16'd5) found = 1;
         else tick();
      end
      if (!found) begin n_fail++; $display("FAIL abort_wait remaining got %0d exp 5", o_burst_remaining); end
      n_checks++;
      i_abort = 1; tick(); i_abort = 0;
      if ({o_gen_en, o_burst_remaining} !== 17'd0) begin
         n_fail++; $display("FAIL abort_now en/rem got %b/%0d exp 0/0", o_gen_en, o_burst_remaining);
      end
      n_checks++;
      for (int c = 0; c < 5; c++) begin
         if (o_done) dones++;
         tick();
      end
      exp_count = exp_count + 32'd3;
      if ({dones[3:0], o_active, o_gen_count} !== {4'd0, 1'b0, exp_count}) begin
         n_fail++; $display("FAIL abort_after dones/active/count got %0d/%b/%0d exp 0/0/%0d", dones, o_active, o_gen_count, exp_count);
      end
      n_checks++;
      // clear on the fire cycle
      i_step = 1; tick(); i_step = 0; tick();
      if (o_gen_en !== 1'b1) begin n_fail++; $display("FAIL clear_fire gen_en got %b exp 1", o_gen_en); end
      n_checks++;
      i_count_clear = 1; tick(); i_count_clear = 0;
      exp_count = 32'd0;
      if ({o_gen_count, s_gen_count} !== 36'd0) begin
         n_fail++; $display("FAIL clear_count got %0d/%0d exp 0/0", o_gen_count, s_gen_count);
      end
      n_checks++;
      // counter wrap on the narrow instance
      for (int k = 1; k <= 16; k++) begin
         i_step = 1; tick(); i_step = 0; tick(); tick();
         exp_count = exp_count + 32'd1;
         if (k >= 15) begin
            if ({s_gen_count, o_gen_count} !== {exp_count[3:0], exp_count}) begin
               n_fail++; $display("FAIL wrap step %0d small/big got %0d/%0d exp %0d/%0d",
                                  k, s_gen_count, o_gen_count, exp_count[3:0], exp_count);
            end
            n_checks++;
         end
      end
   endtask

   task automatic test_random();
      logic [50:0] got, exp;
      logic [22:0] got_s, exp_s;
      reset = 1; tick(); reset = 0;
      for (int c = 0; c < 3000; c++) begin
         reset         = ($urandom_range(0, 999) < 3);
         if ($urandom_range(0, 99) < 5) i_run = ~i_run;
         if ($urandom_range(0, 99) < 3) i_frame_sync_en = ~i_frame_sync_en;
         i_step        = ($urandom_range(0, 99) < 10);
         i_burst_start = ($urandom_range(0, 99) < 4);
         i_burst_count = 16'($urandom_range(0, 5));
         i_abort       = ($urandom_range(0, 99) < 2);
         i_period      = 24'($urandom_range(0, 3));
         i_period_load = ($urandom_range(0, 99) < 5);
         i_hold        = ($urandom_range(0, 99) < 20);
         i_sync_busy   = ($urandom_range(0, 99) < 10);
         i_frame_done  = ($urandom_range(0, 99) < 15);
         i_count_clear = ($urandom_range(0, 99) < 1);
         tick();
         got   = {o_gen_en, o_done, o_active, o_burst_remaining, o_gen_count};
         exp   = {m_gen_en, m_done, m_active, 16'(m_burst), m_count};
         got_s = {s_gen_en, s_done, s_active, s_burst_remaining, s_gen_count};
         exp_s = {m_gen_en, m_done, m_active, 16'(m_burst), m_count[3:0]};
         if (got !== exp) begin
            n_fail++; $display("FAIL random cycle %0d en,done,act,rem,count got %h exp %h", c, got, exp);
         end
         n_checks++;
         if (got_s !== exp_s) begin
            n_fail++; $display("FAIL random_small cycle %0d got %h exp %h", c, got_s, exp_s);
         end
         n_checks++;
      end
   endtask

   initial begin
      reset = 1; i_run = 0; i_step = 0; i_burst_start = 0; i_burst_count = '0; i_abort = 0;
      i_period = '0; i_period_load = 0; i_hold = 0; i_sync_busy = 0; i_frame_sync_en = 0;
      i_frame_done = 0; i_count_clear = 0; exp_count = '0;
      tick(); tick();
      reset = 0;
      test_reset();
      test_single_step();
      test_free_run();
      test_burst();
      test_stall(1'b0);
      test_stall(1'b1);
      test_frame_sync();
      test_corners();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
